mux_scan_ctrl: RTL and testbench

Scan controller that drives the select input of the N:1 bit mux and consumes its single-bit output. It steps through every enabled channel and waits a settle time after each select change. It then majority-votes three samples of the mux output and assembles one N-bit word per scan. The word is presented downstream on a valid/ready handshake, with single-shot and continuous scan modes.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_ctrl_next_ch.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan controller.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  // Samples taken per channel before voting.
  localparam int SAMPLES = 3;

  // Two-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_next_ch.sv
// Priority finder for the scan order: the next enabled channel above the
// current one, and the lowest enabled channel of a freshly launched mask.
module mux_scan_next_ch #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [SELW-1:0] ch,
  input  logic [N-1:0]    new_mask,
  output logic [SELW-1:0] next_ch,
  output logic            has_next,
  output logic [SELW-1:0] first_ch,
  output logic            has_first
);

  // Downward loops so the lowest qualifying index is the last one written.
  always_comb begin
    next_ch   = '0;
    has_next  = 1'b0;
    first_ch  = '0;
    has_first = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(ch))) begin
        next_ch  = SELW'(i);
        has_next = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (new_mask[i]) begin
        first_ch  = SELW'(i);
        has_first = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for an N:1 bit mux: settles after each select change,
// votes three samples per enabled channel and hands the assembled word
// downstream on valid/ready, in single-shot or continuous mode.
//
// state  | meaning
// IDLE   | waiting for start_i (or a pending zero-mask rescan); select held
// SETTLE | settle counter running down after a select change
// SAMPLE | three consecutive captures of mux_dat_i, then vote
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int SETTLE_CYC = 2,
  localparam int SELW       = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            cont_i,
  input  logic [N-1:0]    en_mask_i,
  output logic [SELW-1:0] mux_sel_o,
  input  logic            mux_dat_i,
  output logic            busy_o,
  output logic [N-1:0]    word_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            overrun_o
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;
  localparam state_t ENTRY_STATE = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
  localparam logic [1:0] LAST_SAMPLE = 2'(SAMPLES - 1);

  state_t          state;
  logic [N-1:0]    mask_q;
  logic [N-1:0]    shadow;
  logic [N-1:0]    final_word;
  logic            cont_q;
  logic            rescan;
  logic [SELW-1:0] ch;
  logic [SELW-1:0] next_ch;
  logic [SELW-1:0] first_ch;
  logic            has_next;
  logic            has_first;
  logic [CW-1:0]   settle_cnt;
  logic [1:0]      samp_cnt;
  logic            s0;
  logic            s1;
  logic            vote;

  mux_scan_next_ch #(.N(N), .SELW(SELW)) u_next_ch (
    .mask      (mask_q),
    .ch        (ch),
    .new_mask  (en_mask_i),
    .next_ch   (next_ch),
    .has_next  (has_next),
    .first_ch  (first_ch),
    .has_first (has_first)
  );

  assign vote      = maj3(s0, s1, mux_dat_i);
  assign mux_sel_o = ch;
  assign busy_o    = (state != IDLE);

  // Shadow word with the bit being voted this cycle already merged in.
  always_comb begin
    final_word     = shadow;
    final_word[ch] = vote;
  end

  // Scan sequencing, sample capture and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask_q     <= '0;
      shadow     <= '0;
      cont_q     <= 1'b0;
      rescan     <= 1'b0;
      ch         <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      word_o     <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      rescan <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i || rescan) begin
            mask_q <= en_mask_i;
            cont_q <= cont_i;
            shadow <= '0;
            if (start_i) overrun_o <= 1'b0;
            if (has_first) begin
              ch         <= first_ch;
              settle_cnt <= SETTLE_LOAD;
              samp_cnt   <= '0;
              state      <= ENTRY_STATE;
            end else begin
              // Empty mask: the scan is complete before it starts.
              word_o  <= '0;
              valid_o <= 1'b1;
              if (valid_o && !ready_i) overrun_o <= 1'b1;
              rescan  <= cont_i;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= SAMPLE;
          else settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          samp_cnt <= samp_cnt + 2'd1;
          if (samp_cnt == 2'd0) s0 <= mux_dat_i;
          if (samp_cnt == 2'd1) s1 <= mux_dat_i;
          if (samp_cnt == LAST_SAMPLE) begin
            samp_cnt <= '0;
            shadow   <= final_word;
            if (has_next) begin
              ch         <= next_ch;
              settle_cnt <= SETTLE_LOAD;
              state      <= ENTRY_STATE;
            end else begin
              word_o  <= final_word;
              valid_o <= 1'b1;
              if (valid_o && !ready_i) overrun_o <= 1'b1;
              if (cont_q && cont_i) begin
                mask_q <= en_mask_i;
                cont_q <= cont_i;
                shadow <= '0;
                if (has_first) begin
                  ch         <= first_ch;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ENTRY_STATE;
                end else begin
                  // An empty follow-on mask is reported from IDLE next cycle
                  // so it does not clobber the word just produced.
                  state  <= IDLE;
                  rescan <= 1'b1;
                end
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl (N=4, SETTLE_CYC=2); a 4-bit pattern
// models the mux, with an extra override to inject glitches.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       cont_i;
  logic [3:0] en_mask_i;
  logic [1:0] mux_sel_o;
  logic       mux_dat_i;
  logic       busy_o;
  logic [3:0] word_o;
  logic       valid_o;
  logic       ready_i;
  logic       overrun_o;

  logic [3:0] data_pat;
  logic       force_hi;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_sel;

  assign mux_dat_i = data_pat[mux_sel_o] | force_hi;

  mux_scan_ctrl #(.N(4), .SETTLE_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .cont_i    (cont_i),
    .en_mask_i (en_mask_i),
    .mux_sel_o (mux_sel_o),
    .mux_dat_i (mux_dat_i),
    .busy_o    (busy_o),
    .word_o    (word_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge; returns one cycle after the start edge.
  task automatic launch(input logic [3:0] mask, input logic cont);
    en_mask_i = mask;
    cont_i    = cont;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic accept();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  // Full 4-channel scan of an all-zero pattern with channel 2 forced high
  // for the first n of its three samples (cycles 13..15).
  task automatic run_force(input int n, input logic [3:0] exp_word, input string tag);
    data_pat = 4'b0000;
    launch(4'b1111, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      force_hi = (c >= 13) && (c < 13 + n);
      tick();
    end
    force_hi = 1'b0;
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_word"}, word_o, exp_word);
    accept();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; en_mask_i = '0;
    ready_i = 1'b0; data_pat = '0; force_hi = 1'b0;
    tick(); tick();
    check("rst_sel", mux_sel_o, 2'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_word", word_o, 4'd0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    rst = 1'b0;
    tick();

    // Basic single-shot scan over mask 1011.
    data_pat = 4'b1001;
    launch(4'b1011, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      exp_sel = (c <= 5) ? 2'd0 : ((c <= 10) ? 2'd1 : 2'd3);
      check("basic_sel", mux_sel_o, exp_sel);
      check("basic_busy", busy_o, 1'b1);
      check("basic_valid_early", valid_o, 1'b0);
      tick();
    end
    check("basic_valid", valid_o, 1'b1);
    check("basic_word", word_o, 4'b1001);
    check("basic_busy_end", busy_o, 1'b0);
    tick();
    check("basic_hold_word", word_o, 4'b1001);
    check("basic_hold_valid", valid_o, 1'b1);
    accept();
    check("basic_drop_valid", valid_o, 1'b0);

    // Majority vote: one glitch sample loses, two win.
    run_force(1, 4'b0000, "vote1");
    run_force(2, 4'b0100, "vote2");

    // Continuous scans with no acceptance: overwrite and sticky overrun.
    data_pat = 4'b0110;
    launch(4'b1111, 1'b1);
    repeat (20) tick();
    check("ovr_valid1", valid_o, 1'b1);
    check("ovr_word1", word_o, 4'b0110);
    check("ovr_flag1", overrun_o, 1'b0);
    check("ovr_busy1", busy_o, 1'b1);
    data_pat = 4'b1001;
    repeat (20) tick();
    check("ovr_word2", word_o, 4'b1001);
    check("ovr_valid2", valid_o, 1'b1);
    check("ovr_flag2", overrun_o, 1'b1);
    check("ovr_busy2", busy_o, 1'b1);
    cont_i = 1'b0;
    repeat (20) tick();
    check("ovr_idle", busy_o, 1'b0);
    check("ovr_sticky", overrun_o, 1'b1);
    accept();
    check("ovr_accept", valid_o, 1'b0);
    check("ovr_sticky2", overrun_o, 1'b1);

    // Empty mask start: immediate zero word, clears overrun, never busy.
    launch(4'b0000, 1'b0);
    check("zero_valid", valid_o, 1'b1);
    check("zero_word", word_o, 4'b0000);
    check("zero_ovr_clr", overrun_o, 1'b0);
    check("zero_busy", busy_o, 1'b0);
    tick();
    check("zero_busy2", busy_o, 1'b0);
    check("zero_hold", valid_o, 1'b1);
    accept();

    // Continuous with acceptance exactly at the scan-end cycle.
    data_pat = 4'b0110;
    launch(4'b1111, 1'b1);
    repeat (20) tick();
    check("same_valid1", valid_o, 1'b1);
    check("same_word1", word_o, 4'b0110);
    data_pat = 4'b1001;
    repeat (19) tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("same_valid2", valid_o, 1'b1);
    check("same_word2", word_o, 4'b1001);
    check("same_ovr", overrun_o, 1'b0);
    cont_i = 1'b0;
    repeat (4) tick();
    accept();
    check("same_accept", valid_o, 1'b0);
    repeat (15) tick();
    check("same_end_valid", valid_o, 1'b1);
    check("same_end_busy", busy_o, 1'b0);
    check("same_end_ovr", overrun_o, 1'b0);
    accept();

    // Reset during channel 1 sampling, then a clean sparse scan.
    data_pat = 4'b1111;
    launch(4'b1111, 1'b0);
    repeat (8) tick();
    check("mid_sel", mux_sel_o, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_sel", mux_sel_o, 2'd0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_word", word_o, 4'd0);
    check("mid_rst_valid", valid_o, 1'b0);
    check("mid_rst_ovr", overrun_o, 1'b0);
    launch(4'b0101, 1'b0);
    repeat (5) tick();
    check("post_sel", mux_sel_o, 2'd2);
    check("post_valid_early", valid_o, 1'b0);
    repeat (5) tick();
    check("post_valid", valid_o, 1'b1);
    check("post_word", word_o, 4'b0101);
    check("post_busy", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
